// File: rtl/cpu7_xlat_sched_if.sv
// Request/response bundle between the IFU/LSU translation ports and the
// shared translation scheduler.
interface cpu7_xlat_sched_if #(
  parameter int GRLEN  = 32,
  parameter int PABITS = 32
);
  logic              itlb_req;
  logic [GRLEN-1:0]  itlb_vaddr;
  logic              dtlb_req;
  logic [GRLEN-1:0]  dtlb_vaddr;
  logic              itlb_finish;
  logic [PABITS-1:0] itlb_paddr;
  logic              itlb_hit;
  logic              itlb_uncache;
  logic              dtlb_finish;
  logic [PABITS-1:0] dtlb_paddr;
  logic              dtlb_hit;
  logic              dtlb_uncache;
  logic              busy;
  logic              proto_err;

  // Requester side (IFU/LSU or testbench)
  modport master (
    output itlb_req, itlb_vaddr, dtlb_req, dtlb_vaddr,
    input  itlb_finish, itlb_paddr, itlb_hit, itlb_uncache,
    input  dtlb_finish, dtlb_paddr, dtlb_hit, dtlb_uncache,
    input  busy, proto_err
  );

  // Scheduler side
  modport slave (
    input  itlb_req, itlb_vaddr, dtlb_req, dtlb_vaddr,
    output itlb_finish, itlb_paddr, itlb_hit, itlb_uncache,
    output dtlb_finish, dtlb_paddr, dtlb_hit, dtlb_uncache,
    output busy, proto_err
  );
endinterface

// File: rtl/cpu7_xlat_sched.sv
// Shared address-translation slot for the inst (itlb) and data (dtlb) ports.
// Requests are held in one pending entry per port, arbitrated round-robin,
// translated (identity map plus uncached-segment decode) over LAT cycles and
// answered with a one-cycle finish pulse on the requesting port.
module cpu7_xlat_sched #(
  parameter int         GRLEN  = 32,
  parameter int         PABITS = 32,
  parameter int         LAT    = 1,
  parameter bit         UC_EN  = 1'b1,
  parameter logic [2:0] UC_SEG = 3'b101
) (
  input logic              clk,
  input logic              reset,
  cpu7_xlat_sched_if.slave bus
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_XLAT = 1'b1} state_e;

  // Uncached attribute of a virtual address
  function automatic logic uc_decode(input logic [GRLEN-1:0] va);
    return UC_EN && (va[GRLEN-1:GRLEN-3] == UC_SEG);
  endfunction

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sel_q, sel_d;          // 0 = inst, 1 = data
  logic [GRLEN-1:0]  cur_vaddr_q, cur_vaddr_d;
  logic              last_q, last_d;        // last granted port, 0 = inst
  logic              i_pend_q, i_pend_d;
  logic [GRLEN-1:0]  i_vaddr_q, i_vaddr_d;
  logic              d_pend_q, d_pend_d;
  logic [GRLEN-1:0]  d_vaddr_q, d_vaddr_d;
  logic              i_fin_q, i_fin_d;
  logic [PABITS-1:0] i_paddr_q, i_paddr_d;
  logic              i_uc_q, i_uc_d;
  logic              d_fin_q, d_fin_d;
  logic [PABITS-1:0] d_paddr_q, d_paddr_d;
  logic              d_uc_q, d_uc_d;
  logic              err_q, err_d;

  logic             i_bad, d_bad, i_live, d_live, i_cand, d_cand;
  logic [GRLEN-1:0] i_cand_va, d_cand_va;
  logic             gnt_vld, gnt_sel;
  logic [GRLEN-1:0] gnt_va;
  logic             fin_vld, fin_sel;
  logic [GRLEN-1:0] fin_va;

  // Candidate selection, protocol check and round-robin grant
  always_comb begin
    i_bad     = bus.itlb_req && (i_pend_q || (state_q == S_XLAT && !sel_q));
    d_bad     = bus.dtlb_req && (d_pend_q || (state_q == S_XLAT && sel_q));
    i_live    = bus.itlb_req && !i_bad;
    d_live    = bus.dtlb_req && !d_bad;
    i_cand    = i_pend_q || i_live;
    d_cand    = d_pend_q || d_live;
    i_cand_va = i_pend_q ? i_vaddr_q : bus.itlb_vaddr;
    d_cand_va = d_pend_q ? d_vaddr_q : bus.dtlb_vaddr;
    gnt_vld   = (state_q == S_IDLE) && (i_cand || d_cand);
    gnt_sel   = (i_cand && d_cand) ? !last_q : d_cand;
    gnt_va    = gnt_sel ? d_cand_va : i_cand_va;
    if (LAT == 1) begin
      fin_vld = gnt_vld;
      fin_sel = gnt_sel;
      fin_va  = gnt_va;
    end else begin
      fin_vld = (state_q == S_XLAT) && (cnt_q == CW'(1));
      fin_sel = sel_q;
      fin_va  = cur_vaddr_q;
    end
  end

  // Next-state logic of the translation slot
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld && LAT > 1) begin
          state_d = S_XLAT;
          cnt_d   = CW'(LAT - 1);
        end
      end
      S_XLAT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending capture, grant bookkeeping and registered response outputs
  always_comb begin
    sel_d       = gnt_vld ? gnt_sel : sel_q;
    cur_vaddr_d = gnt_vld ? gnt_va : cur_vaddr_q;
    last_d      = gnt_vld ? gnt_sel : last_q;
    i_pend_d    = i_pend_q;
    i_vaddr_d   = i_vaddr_q;
    d_pend_d    = d_pend_q;
    d_vaddr_d   = d_vaddr_q;
    if (gnt_vld && !gnt_sel) begin
      i_pend_d = 1'b0;
    end else if (i_live) begin
      i_pend_d  = 1'b1;
      i_vaddr_d = bus.itlb_vaddr;
    end
    if (gnt_vld && gnt_sel) begin
      d_pend_d = 1'b0;
    end else if (d_live) begin
      d_pend_d  = 1'b1;
      d_vaddr_d = bus.dtlb_vaddr;
    end
    i_fin_d   = fin_vld && !fin_sel;
    d_fin_d   = fin_vld && fin_sel;
    i_paddr_d = i_fin_d ? fin_va[PABITS-1:0] : i_paddr_q;
    i_uc_d    = i_fin_d ? uc_decode(fin_va) : i_uc_q;
    d_paddr_d = d_fin_d ? fin_va[PABITS-1:0] : d_paddr_q;
    d_uc_d    = d_fin_d ? uc_decode(fin_va) : d_uc_q;
    err_d     = err_q || i_bad || d_bad;
  end

  // Control state and outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      last_q    <= 1'b0;
      i_pend_q  <= 1'b0;
      d_pend_q  <= 1'b0;
      i_fin_q   <= 1'b0;
      i_paddr_q <= '0;
      i_uc_q    <= 1'b0;
      d_fin_q   <= 1'b0;
      d_paddr_q <= '0;
      d_uc_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      i_pend_q  <= i_pend_d;
      d_pend_q  <= d_pend_d;
      i_fin_q   <= i_fin_d;
      i_paddr_q <= i_paddr_d;
      i_uc_q    <= i_uc_d;
      d_fin_q   <= d_fin_d;
      d_paddr_q <= d_paddr_d;
      d_uc_q    <= d_uc_d;
      err_q     <= err_d;
    end
  end

  // Address holding registers, qualified by the pend/state bits above
  always_ff @(posedge clk) begin
    cur_vaddr_q <= cur_vaddr_d;
    i_vaddr_q   <= i_vaddr_d;
    d_vaddr_q   <= d_vaddr_d;
  end

  assign bus.itlb_finish  = i_fin_q;
  assign bus.itlb_hit     = i_fin_q;
  assign bus.itlb_paddr   = i_paddr_q;
  assign bus.itlb_uncache = i_uc_q;
  assign bus.dtlb_finish  = d_fin_q;
  assign bus.dtlb_hit     = d_fin_q;
  assign bus.dtlb_paddr   = d_paddr_q;
  assign bus.dtlb_uncache = d_uc_q;
  assign bus.busy         = (state_q == S_XLAT);
  assign bus.proto_err    = err_q;

endmodule

// File: tb/tb_cpu7_xlat_sched.sv
// Bench for cpu7_xlat_sched: a LAT=1 and a LAT=3 instance driven in lock-step,
// each compared every cycle against a timestamp-based reference model, plus
// directed checks of the documented scenarios.
module tb_cpu7_xlat_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu7_xlat_sched_if #(.GRLEN(32), .PABITS(32)) if1 ();
  cpu7_xlat_sched_if #(.GRLEN(32), .PABITS(32)) if3 ();

  cpu7_xlat_sched #(.GRLEN(32), .PABITS(32), .LAT(1), .UC_EN(1'b1), .UC_SEG(3'b101))
    u_lat1 (.clk(clk), .reset(rst), .bus(if1.slave));
  cpu7_xlat_sched #(.GRLEN(32), .PABITS(32), .LAT(3), .UC_EN(1'b1), .UC_SEG(3'b101))
    u_lat3 (.clk(clk), .reset(rst), .bus(if3.slave));

  int checks = 0;
  int errors = 0;
  int t = 0;
  bit mvalid = 1'b0;

  // Reference model: per instance [k], per port [p] (0 = inst, 1 = data)
  bit          pend [2][2];
  logic [31:0] pv   [2][2];
  bit          fl_vld [2];
  int          fl_port [2];
  logic [31:0] fl_va [2];
  int          fl_t [2];
  int          gnt_t [2];
  bit          last [2];
  bit          merr [2];
  logic [31:0] e_paddr [2][2];
  bit          e_uc [2][2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ir, input logic [31:0] iv, input bit dr, input logic [31:0] dv);
    if1.itlb_req = ir; if1.itlb_vaddr = iv; if1.dtlb_req = dr; if1.dtlb_vaddr = dv;
    if3.itlb_req = ir; if3.itlb_vaddr = iv; if3.dtlb_req = dr; if3.dtlb_vaddr = dv;
  endtask

  task automatic model_cycle(input bit rs, input bit ir, input logic [31:0] iv,
                             input bit dr, input logic [31:0] dv);
    bit          req [2];
    logic [31:0] va [2];
    logic [31:0] o_fin [2][2];
    logic [31:0] o_hit [2][2];
    logic [31:0] o_pa  [2][2];
    logic [31:0] o_uc  [2][2];
    logic [31:0] o_busy [2];
    logic [31:0] o_err [2];
    req[0] = ir; req[1] = dr; va[0] = iv; va[1] = dv;
    o_fin[0][0] = 32'(if1.itlb_finish); o_fin[0][1] = 32'(if1.dtlb_finish);
    o_hit[0][0] = 32'(if1.itlb_hit);    o_hit[0][1] = 32'(if1.dtlb_hit);
    o_pa[0][0]  = if1.itlb_paddr;       o_pa[0][1]  = if1.dtlb_paddr;
    o_uc[0][0]  = 32'(if1.itlb_uncache); o_uc[0][1] = 32'(if1.dtlb_uncache);
    o_busy[0]   = 32'(if1.busy);        o_err[0]    = 32'(if1.proto_err);
    o_fin[1][0] = 32'(if3.itlb_finish); o_fin[1][1] = 32'(if3.dtlb_finish);
    o_hit[1][0] = 32'(if3.itlb_hit);    o_hit[1][1] = 32'(if3.dtlb_hit);
    o_pa[1][0]  = if3.itlb_paddr;       o_pa[1][1]  = if3.dtlb_paddr;
    o_uc[1][0]  = 32'(if3.itlb_uncache); o_uc[1][1] = 32'(if3.dtlb_uncache);
    o_busy[1]   = 32'(if3.busy);        o_err[1]    = 32'(if3.proto_err);
    for (int k = 0; k < 2; k++) begin
      bit fin [2];
      bit busy_e;
      for (int p = 0; p < 2; p++) begin
        fin[p] = fl_vld[k] && (fl_t[k] == t) && (fl_port[k] == p);
        if (fin[p]) begin
          e_paddr[k][p] = fl_va[k];
          e_uc[k][p]    = (fl_va[k][31:29] == 3'b101);
        end
      end
      busy_e = fl_vld[k] && (gnt_t[k] < t) && (t < fl_t[k]);
      if (mvalid) begin
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("lat%0d_p%0d_finish_c%0d", lat_of(k), p, t), o_fin[k][p], 32'(fin[p]));
          chk($sformatf("lat%0d_p%0d_hit_c%0d", lat_of(k), p, t), o_hit[k][p], 32'(fin[p]));
          chk($sformatf("lat%0d_p%0d_paddr_c%0d", lat_of(k), p, t), o_pa[k][p], e_paddr[k][p]);
          chk($sformatf("lat%0d_p%0d_uncache_c%0d", lat_of(k), p, t), o_uc[k][p], 32'(e_uc[k][p]));
        end
        chk($sformatf("lat%0d_busy_c%0d", lat_of(k), t), o_busy[k], 32'(busy_e));
        chk($sformatf("lat%0d_proto_err_c%0d", lat_of(k), t), o_err[k], 32'(merr[k]));
      end
      if (fl_vld[k] && fl_t[k] == t) fl_vld[k] = 1'b0;
      if (rs) begin
        fl_vld[k] = 1'b0; last[k] = 1'b0; merr[k] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          pend[k][p] = 1'b0; e_paddr[k][p] = '0; e_uc[k][p] = 1'b0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (req[p]) begin
            if (pend[k][p] || (fl_vld[k] && fl_port[k] == p)) merr[k] = 1'b1;
            else begin
              pend[k][p] = 1'b1;
              pv[k][p]   = va[p];
            end
          end
        end
        if (!fl_vld[k] && (pend[k][0] || pend[k][1])) begin
          int g;
          if (pend[k][0] && pend[k][1]) g = last[k] ? 0 : 1;
          else g = pend[k][1] ? 1 : 0;
          fl_vld[k] = 1'b1; fl_port[k] = g; fl_va[k] = pv[k][g];
          fl_t[k] = t + lat_of(k); gnt_t[k] = t;
          last[k] = (g == 1); pend[k][g] = 1'b0;
        end
      end
    end
    if (rs) mvalid = 1'b1;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance
  task automatic step(input bit rs, input bit ir, input logic [31:0] iv,
                      input bit dr, input logic [31:0] dv);
    rst = rs;
    drive(ir, iv, dr, dv);
    @(negedge clk);
    model_cycle(rs, ir, iv, dr, dv);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    int fcnt;
    bit ir, dr, rs;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("reset_busy3", 32'(if3.busy), 32'h0);
    chk("reset_err3", 32'(if3.proto_err), 32'h0);
    chk("reset_paddr1", if1.itlb_paddr, 32'h0);
    chk("reset_dfin3", 32'(if3.dtlb_finish), 32'h0);
    idle(2);

    // T1: single inst request on LAT=1
    step(1'b0, 1'b1, 32'h1c000010, 1'b0, 32'h0);
    chk("t1_ifin", 32'(if1.itlb_finish), 32'h1);
    chk("t1_ipaddr", if1.itlb_paddr, 32'h1c000010);
    chk("t1_ihit", 32'(if1.itlb_hit), 32'h1);
    chk("t1_iuc", 32'(if1.itlb_uncache), 32'h0);
    idle(4);

    // T2: simultaneous first requests after reset, data wins
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h00000100, 1'b1, 32'h00000200);
    chk("t2_dfin", 32'(if1.dtlb_finish), 32'h1);
    chk("t2_ifin_not_yet", 32'(if1.itlb_finish), 32'h0);
    chk("t2_dpaddr", if1.dtlb_paddr, 32'h00000200);
    idle(1);
    chk("t2_ifin", 32'(if1.itlb_finish), 32'h1);
    chk("t2_ipaddr", if1.itlb_paddr, 32'h00000100);
    idle(6);

    // T3: both ports keep one request outstanding, re-requesting on finish
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, $urandom, 1'b1, $urandom);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3_dfin_%0d", k), 32'(if1.dtlb_finish), 32'((k % 2) == 0));
      chk($sformatf("t3_ifin_%0d", k), 32'(if1.itlb_finish), 32'((k % 2) == 1));
      step(1'b0, if1.itlb_finish, $urandom, if1.dtlb_finish, $urandom);
    end
    chk("t3_no_proto_err", 32'(if1.proto_err), 32'h0);
    idle(6);

    // T4: LAT=3 latency and queued inst request
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(2);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h00003000);
    chk("t4_busy_c1", 32'(if3.busy), 32'h1);
    step(1'b0, 1'b1, 32'h00004000, 1'b0, 32'h0);
    chk("t4_busy_c2", 32'(if3.busy), 32'h1);
    chk("t4_dfin_not_yet", 32'(if3.dtlb_finish), 32'h0);
    idle(1);
    chk("t4_dfin_c3", 32'(if3.dtlb_finish), 32'h1);
    chk("t4_busy_c3", 32'(if3.busy), 32'h0);
    idle(3);
    chk("t4_ifin_c6", 32'(if3.itlb_finish), 32'h1);
    chk("t4_ipaddr", if3.itlb_paddr, 32'h00004000);
    idle(2);

    // T5: uncached segment decode
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'ha0001000);
    chk("t5_uc1", 32'(if1.dtlb_uncache), 32'h1);
    chk("t5_pa1", if1.dtlb_paddr, 32'ha0001000);
    idle(4);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h80001000);
    chk("t5_uc0", 32'(if1.dtlb_uncache), 32'h0);
    idle(4);

    // T6a: re-request while in flight on LAT=3
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    fcnt = 0;
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h00005000);
    fcnt += int'(if3.dtlb_finish);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h00006000);
    fcnt += int'(if3.dtlb_finish);
    chk("t6_err_c2", 32'(if3.proto_err), 32'h1);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      fcnt += int'(if3.dtlb_finish);
    end
    chk("t6_one_finish", 32'(fcnt), 32'h1);
    chk("t6_paddr", if3.dtlb_paddr, 32'h00005000);

    // T6b: reset while in flight drops the request
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h00007000);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h00008000);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t6b_no_fin", 32'(if3.dtlb_finish), 32'h0);
    chk("t6b_err_clr", 32'(if3.proto_err), 32'h0);
    chk("t6b_busy", 32'(if3.busy), 32'h0);
    idle(4);
    chk("t6b_still_no_fin", 32'(if3.dtlb_finish), 32'h0);

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 59) == 0);
      ir = ($urandom_range(0, 2) == 0);
      dr = ($urandom_range(0, 2) == 0);
      step(rs, ir, $urandom, dr, $urandom);
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
